// File: rtl/xor_frame_checksum.sv
// Folds a 5-bit word stream into one XOR checksum per frame.
// Latency: the result is valid in the cycle after the final word is accepted.
// Backpressure: in_ready drops while a result waits for out_ready. There is no bypass.

module xorFiveBits (
  input  logic [4:0] a,
  input  logic [4:0] b,
  output logic [4:0] y
);
  assign y = a ^ b;
endmodule

module xor_frame_checksum #(
  parameter int WIDTH     = 5,
  parameter int FRAME_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_checksum,
  output logic [3:0]       out_len
);

  localparam logic [3:0] FL = 4'(FRAME_LEN);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] nxt;
  logic [3:0]       cnt;
  logic [3:0]       cnt_inc;
  logic             acc_en;

  xorFiveBits u_xor (
    .a (acc),
    .b (in_data),
    .y (nxt)
  );

  assign in_ready = (state != HOLD);
  assign acc_en   = in_valid & in_ready;
  assign cnt_inc  = cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      acc          <= '0;
      cnt          <= '0;
      out_valid    <= 1'b0;
      out_checksum <= '0;
      out_len      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (acc_en) begin
            if (in_last || FL == 4'd1) begin
              out_checksum <= in_data;
              out_len      <= 4'd1;
              out_valid    <= 1'b1;
              state        <= HOLD;
            end else begin
              acc   <= in_data;
              cnt   <= 4'd1;
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (acc_en) begin
            if (in_last || cnt_inc == FL) begin
              out_checksum <= nxt;
              out_len      <= cnt_inc;
              out_valid    <= 1'b1;
              acc          <= '0;
              cnt          <= '0;
              state        <= HOLD;
            end else begin
              acc <= nxt;
              cnt <= cnt_inc;
            end
          end
        end
        HOLD: begin
          // Result registers keep their values after the handshake.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_frame_checksum.sv
// Scoreboard bench: each frame pushes its hand-computed result, and a monitor pops on every output handshake.
module tb_xor_frame_checksum;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_checksum;
  logic [3:0] out_len;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [4:0] sum;
    logic [3:0] len;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  xor_frame_checksum #(.WIDTH(5), .FRAME_LEN(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_checksum (out_checksum),
    .out_len      (out_len)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops one expected result on every output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(out_checksum), 32'h1f);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_checksum", 32'(out_checksum), 32'(e.sum));
        chk("sb_len", 32'(out_len), 32'(e.len));
      end
    end
  end

  task automatic send(input logic [4:0] d, input logic l);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic push(input logic [4:0] s, input logic [3:0] n);
    exp_t e;
    e.sum = s;
    e.len = n;
    exp_q.push_back(e);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic bubble(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in_last  = 1'b1;
      in_data  = 5'b11111;
      @(posedge clk); #1;
    end
    in_last = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_checksum", 32'(out_checksum), 32'h0);
    chk("rst_out_len", 32'(out_len), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);

    // Full frame, out_ready high: one HOLD cycle only
    push(5'b10000, 4'd4);
    send(5'b11111, 1'b0);
    send(5'b00111, 1'b0);
    send(5'b11000, 1'b0);
    send(5'b10000, 1'b0);
    chk("full_out_valid", 32'(out_valid), 32'h1);
    chk("full_in_ready_hold", 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    chk("full_in_ready_after", 32'(in_ready), 32'h1);
    chk("full_out_valid_after", 32'(out_valid), 32'h0);

    // Early last: single-word frame, then a zero-checksum pair
    push(5'b00010, 4'd1);
    send(5'b00010, 1'b1);
    push(5'b00000, 4'd2);
    send(5'b00000, 1'b0);
    send(5'b00000, 1'b1);
    chk("zero_sum_valid", 32'(out_valid), 32'h1);
    @(posedge clk); #1;

    // Output backpressure
    out_ready = 1'b0;
    push(5'b00001, 4'd4);
    send(5'b11000, 1'b0);
    send(5'b11000, 1'b0);
    send(5'b00001, 1'b0);
    send(5'b00000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'h1);
      chk("bp_checksum", 32'(out_checksum), 32'h01);
      chk("bp_len", 32'(out_len), 32'h4);
      chk("bp_in_ready", 32'(in_ready), 32'h0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", 32'(out_valid), 32'h0);
    chk("bp_release_in_ready", 32'(in_ready), 32'h1);

    // Input bubbles with garbage data and stray in_last while invalid
    push(5'b00000, 4'd4);
    send(5'b10101, 1'b0);
    bubble(2);
    send(5'b01010, 1'b0);
    bubble(1);
    send(5'b11111, 1'b0);
    bubble(3);
    send(5'b00000, 1'b0);
    chk("bubble_out_len", 32'(out_len), 32'h4);
    @(posedge clk); #1;

    // Reset mid-frame discards partial accumulation
    send(5'b10000, 1'b0);
    send(5'b01000, 1'b0);
    pulse_reset();
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    chk("midrst_in_ready", 32'(in_ready), 32'h1);
    push(5'b00010, 4'd4);
    send(5'b00011, 1'b0);
    send(5'b00001, 1'b0);
    send(5'b00000, 1'b0);
    send(5'b00000, 1'b0);
    @(posedge clk); #1;
    chk("queue_drained_before_hold_rst", 32'(exp_q.size()), 32'h0);

    // Reset while a result is pending in HOLD
    out_ready = 1'b0;
    push(5'b00100, 4'd1);
    send(5'b00100, 1'b1);
    @(posedge clk); #1;
    chk("hold_pending_valid", 32'(out_valid), 32'h1);
    exp_q.delete();
    out_ready = 1'b1;
    pulse_reset();
    chk("holdrst_out_valid", 32'(out_valid), 32'h0);
    chk("holdrst_out_checksum", 32'(out_checksum), 32'h0);
    chk("holdrst_out_len", 32'(out_len), 32'h0);
    chk("holdrst_in_ready", 32'(in_ready), 32'h1);
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("final_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xor_frame_checksum.md
Name: xor_frame_checksum

Overview:
- Sequential stage directly downstream of the 5-bit bitwise XOR block (xorFiveBits), which it instantiates as its combining element.
- Accepts a stream of 5-bit words over a valid/ready handshake and folds each word into a running XOR checksum.
- Presents one checksum per frame, with the frame word count, on an output valid/ready handshake.
- A frame ends after FRAME_LEN words or on an early in_last, whichever comes first.

Parameters:
- WIDTH, 5, data and checksum width; it must equal the xorFiveBits operand width.
- FRAME_LEN, 4, maximum words per frame; legal range is 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a word
- in_data  input  WIDTH  word to fold into the checksum
- in_last  input  1  marks the final word of a short frame; qualified by in_valid
- out_valid  output  1  out_checksum and out_len are valid
- out_ready  input  1  downstream accepts the result
- out_checksum  output  WIDTH  XOR of all words in the frame
- out_len  output  4  number of words in the frame, 1..FRAME_LEN

Behaviour:
- Reset: one clock edge with rst_n=0 sets the following. Reset is synchronous only; rst_n has no asynchronous effect.
  - state=IDLE, acc=0, cnt=0.
  - out_valid=0, out_checksum=0, out_len=0.
  - in_ready=1 in the first cycle after reset.
- Reset mid-operation: a reset in ACCUM or HOLD discards the partial frame or pending result. The discarded data is never presented.
- Accept condition: acc_en = in_valid & in_ready.
- Combining: nxt = acc XOR in_data, formed by the xorFiveBits instance (operands acc, in_data). Width is WIDTH; there is no carry or overflow.
- in_ready = (state != HOLD). It does not depend combinationally on out_ready; there is no bypass.
- States:
  - IDLE (cnt=0, acc=0):
    - acc_en & (in_last | FRAME_LEN==1): out_checksum<=in_data, out_len<=1, out_valid<=1, go to HOLD.
    - acc_en otherwise: acc<=in_data, cnt<=1, go to ACCUM.
    - No acc_en: stay in IDLE.
  - ACCUM:
    - acc_en & (in_last | cnt+1==FRAME_LEN): out_checksum<=nxt, out_len<=cnt+1, out_valid<=1, acc<=0, cnt<=0, go to HOLD.
    - acc_en otherwise: acc<=nxt, cnt<=cnt+1.
    - No acc_en: hold acc and cnt indefinitely. There is no timeout.
  - HOLD:
    - out_valid=1. out_checksum and out_len stay stable until out_valid & out_ready.
    - On the handshake: out_valid<=0, go to IDLE.
    - out_checksum and out_len keep their last values after the handshake; they are don't-care while out_valid=0.
- Latency: out_valid rises on the clock edge that accepts the final word. The result is visible in the cycle after that word's handshake.
- Throughput: at most one frame per FRAME_LEN+1 cycles, because of the HOLD cycle.
- Boundary cases:
  - in_last asserted without in_valid is ignored.
  - in_data changing while in_valid=0 has no effect.
  - in_last on the FRAME_LEN-th word is the same as a full frame; len=FRAME_LEN.
  - out_ready held high continuously gives exactly one HOLD cycle per frame.
  - Words presented while in HOLD are not accepted (in_ready=0). Upstream must hold them.
  - An all-equal-pair frame yields checksum 00000 with out_valid=1. A zero checksum is still a valid result.

Test Plan:
- Full frame, out_ready=1: words 11111, 00111, 11000, 10000 on consecutive cycles. Expect out_valid=1 the next cycle, out_checksum=10000, out_len=4, and in_ready=0 for exactly one cycle.
- Early last: single word 00010 with in_last=1. Expect out_checksum=00010, out_len=1. Then 00000, 00000 with last on the second word. Expect checksum 00000, len 2.
- Output backpressure: complete the frame 11000, 11000, 00001, 00000 with out_ready=0 for 5 cycles. Expect checksum 00001 and len 4 to stay stable and in_ready=0 throughout. After out_ready=1 for one cycle, expect out_valid=0 and in_ready=1.
- Input bubbles: frame 10101, 01010, 11111, 00000 with in_valid toggling (idle cycles between words, in_data=11111 garbage while invalid). Expect checksum 00000, len 4; the garbage is not included.
- Reset mid-frame: after accepting 10000 and 01000, apply rst_n=0 for one edge. Then send 00011, 00001, 00000, 00000. Expect checksum 00010, len 4, and no stale result.
- Reset in HOLD: hold a pending result with out_ready=0, then apply rst_n=0. Expect out_valid=0, out_checksum=0, out_len=0 and in_ready=1 on the next cycle.
